// File: rtl/pram_ctrl.sv
// pram_ctrl: request/response front end for the single port of a pram block RAM.
// Absorbs the RAM's one-cycle registered read latency and buffers up to two
// responses so that no read data is lost while the response side stalls.
//
// Optional feature macro: PRAM_CTRL_RMW_EN
//   defined   -> byte-strobed partial writes are performed as read-modify-write
//                through a two-state FSM (IDLE, RMW_WR)
//   undefined -> req_wstrb is ignored and every write is a full-word write
//
// Handshakes: a transfer happens on a rising clka edge where valid and ready
// are both high; valid never waits on ready, and the payload must be held
// stable by the source while valid is high and ready is low.
module pram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_wen,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta
);

    // Response FIFO and the single in-flight RAM access tracker.
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_wen_q, inflight_wen_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]            fifo_wen_q;
    logic                  rd_ptr_q, wr_ptr_q;

    logic                  accept;
    logic                  pop;
    logic                  pop_fifo;
    logic                  push;
    logic [1:0]            occupancy;
    logic                  slot_free;

    // Every accepted access will eventually need a FIFO slot; count the one
    // still in flight so that the FIFO can never be asked to hold a third word.
    assign occupancy = count_q + {1'b0, inflight_q};
    assign slot_free = (occupancy < 2'd2);

`ifdef PRAM_CTRL_RMW_EN
    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rmw_addr_q;
    logic [DATA_WIDTH-1:0] rmw_wdata_q;
    logic [STRB_WIDTH-1:0] rmw_wstrb_q;
    logic                  strb_zero;
    logic                  partial;
    logic [DATA_WIDTH-1:0] merged;

    assign strb_zero = (req_wstrb == '0);
    assign partial   = req_wen && !strb_zero && (req_wstrb != '1);

    // Merge the latched write bytes over the old word returned by the RMW read.
    always_comb begin
        merged = ram_douta;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (rmw_wstrb_q[b]) begin
                merged[8*b +: 8] = rmw_wdata_q[8*b +: 8];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the partial write so its write half can be issued next cycle.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_wstrb_q <= '0;
        end else if (accept && partial) begin
            rmw_addr_q  <= req_addr;
            rmw_wdata_q <= req_wdata;
            rmw_wstrb_q <= req_wstrb;
        end
    end

    // Next state, request acceptance and RAM port drive.
    always_comb begin
        state_d        = state_q;
        req_ready      = (state_q == IDLE) && slot_free;
        accept         = req_valid && req_ready;
        ram_ena        = 1'b0;
        ram_wea        = 1'b0;
        ram_addra      = req_addr;
        ram_dina       = req_wdata;
        inflight_d     = 1'b0;
        inflight_wen_d = inflight_wen_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ram_ena = 1'b1;
                    if (partial) begin
                        // Read half only; the response comes from the write half.
                        state_d = RMW_WR;
                    end else begin
                        // All-zero strobes degrade to a read that still echoes wen.
                        ram_wea        = req_wen && !strb_zero;
                        inflight_d     = 1'b1;
                        inflight_wen_d = req_wen;
                    end
                end
            end
            RMW_WR: begin
                // Read-first RAM returns the old word for this write next cycle.
                ram_ena        = 1'b1;
                ram_wea        = 1'b1;
                ram_addra      = rmw_addr_q;
                ram_dina       = merged;
                inflight_d     = 1'b1;
                inflight_wen_d = 1'b1;
                state_d        = IDLE;
            end
        endcase
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^req_wstrb;

    // Request acceptance and RAM port drive; every write is a full word.
    always_comb begin
        req_ready      = slot_free;
        accept         = req_valid && req_ready;
        ram_ena        = accept;
        ram_wea        = accept && req_wen;
        ram_addra      = req_addr;
        ram_dina       = req_wdata;
        inflight_d     = accept;
        inflight_wen_d = accept ? req_wen : inflight_wen_q;
    end
`endif

    // Response head selection, FIFO push/pop decisions and next count.
    always_comb begin
        resp_valid = (count_q != 2'd0) || inflight_q;
        if (count_q != 2'd0) begin
            resp_rdata = fifo_data_q[rd_ptr_q];
            resp_wen   = fifo_wen_q[rd_ptr_q];
        end else begin
            resp_rdata = ram_douta;
            resp_wen   = inflight_wen_q;
        end
        pop      = resp_valid && resp_ready;
        pop_fifo = pop && (count_q != 2'd0);
        // The in-flight word bypasses the FIFO only when it is the head and is taken.
        push     = inflight_q && !(pop && (count_q == 2'd0));
        count_d  = count_q + {1'b0, push} - {1'b0, pop_fifo};
    end

    // In-flight tracker and FIFO occupancy.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            count_q        <= 2'd0;
            inflight_q     <= 1'b0;
            inflight_wen_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            inflight_q     <= inflight_d;
            inflight_wen_q <= inflight_wen_d;
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_wen_q     <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= ram_douta;
                fifo_wen_q[wr_ptr_q]  <= inflight_wen_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_fifo) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_pram_ctrl.sv
// Testbench for pram_ctrl: behavioural read-first RAM, a word-level reference
// memory with an expected-response queue, directed steps and a random phase.
module tb_pram_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = DW / 8;

    logic          clka;
    logic          rsta_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_wen;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic [DW-1:0] ram_douta;

    pram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clka       (clka),
        .rsta_n     (rsta_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_wen   (resp_wen),
        .ram_ena    (ram_ena),
        .ram_wea    (ram_wea),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_douta  (ram_douta)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural read-first RAM ----------------
    logic [DW-1:0] ram_mem [1 << AW];

    always @(posedge clka) begin
        if (ram_ena) begin
            ram_douta <= ram_mem[ram_addra];
            if (ram_wea) ram_mem[ram_addra] <= ram_dina;
        end
    end

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW:0]   exp_q[$];
    logic          hold_pend = 1'b0;
    logic [DW:0]   hold_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a word memory; each accepted request yields {wen, old word}.
    task automatic model_accept(input logic wen, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        old_w = ref_mem[addr];
        new_w = old_w;
`ifdef PRAM_CTRL_RMW_EN
        for (int b = 0; b < SW; b++) begin
            if (wen && strb[b]) new_w[8*b +: 8] = wdata[8*b +: 8];
        end
`else
        if (wen) new_w = wdata;
`endif
        ref_mem[addr] = new_w;
        exp_q.push_back({wen, old_w});
    endtask

    // Mid-cycle monitor: response ordering/data, hold stability, request capture.
    always @(negedge clka) begin
        if (!rsta_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("resp_hold_valid", resp_valid, 1'b1);
                check("resp_hold_data", {resp_wen, resp_rdata}, hold_val);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    assert (exp_q.size() != 0) else begin
                        n_fail++;
                        $error("FAIL resp_unexpected: observed %h expected none", {resp_wen, resp_rdata});
                    end
                end else begin
                    check("resp_data", {resp_wen, resp_rdata}, exp_q.pop_front());
                end
            end
            if (req_valid && req_ready) model_accept(req_wen, req_addr, req_wdata, req_wstrb);
            hold_pend = resp_valid && !resp_ready;
            hold_val  = {resp_wen, resp_rdata};
        end
    end

    // ---------------- driver tasks ----------------
    // Called and returning at 1 time unit after a rising edge.
    task automatic send(input logic wen, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        @(negedge clka);
        while (!req_ready && waited < 20) begin
            waited++;
            @(negedge clka);
        end
        if (!req_ready) check("send_timeout", req_ready, 1'b1);
        @(posedge clka);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k          = 0;
        resp_ready = 1'b1;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clka);
            #1;
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int            acc;
        int            k;
        logic          fired;
        logic [DW-1:0] saved;

        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_douta  = '0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b1;
        rsta_n     = 1'b1;
        #1 rsta_n  = 1'b0;
        #1;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_ram_ena", ram_ena, 1'b0);
        check("rst_resp_wen", resp_wen, 1'b0);
        repeat (2) @(posedge clka);
        #1 rsta_n = 1'b1;

        // Write then read address 5; each response arrives the cycle after accept.
        send(1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
        @(negedge clka);
        check("wr_resp_valid", resp_valid, 1'b1);
        check("wr_resp_wen", resp_wen, 1'b1);
        check("wr_resp_old", resp_rdata, 32'h0);
        @(posedge clka); #1;
        send(1'b0, 10'd5, 32'h0, 4'h0);
        @(negedge clka);
        check("rd_resp_valid", resp_valid, 1'b1);
        check("rd_resp_data", resp_rdata, 32'hDEADBEEF);
        @(posedge clka); #1;

        // Fill 0..7 and 16..19 with random words.
        for (int i = 0; i < 8; i++) send(1'b1, AW'(i), $urandom, 4'hF);
        for (int i = 16; i < 20; i++) send(1'b1, AW'(i), $urandom, 4'hF);
        drain();

        // Back-to-back reads: one per cycle, responses on consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_wen   = 1'b0;
            req_addr  = AW'(i);
            @(negedge clka);
            check("b2b_req_ready", req_ready, 1'b1);
            if (i > 0) check("b2b_resp_valid", resp_valid, 1'b1);
            @(posedge clka); #1;
        end
        req_valid = 1'b0;
        @(negedge clka);
        check("b2b_last_resp_valid", resp_valid, 1'b1);
        @(posedge clka); #1;
        drain();

        // Backpressure: 4 reads offered with responses stalled.
        resp_ready = 1'b0;
        acc        = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_wen   = 1'b0;
            req_addr  = AW'(16 + acc);
            @(negedge clka);
            if (req_valid && req_ready) acc++;
            @(posedge clka); #1;
        end
        req_addr = AW'(16 + acc);
        check("bp_accepted", acc, 2);
        @(negedge clka);
        check("bp_req_ready_low", req_ready, 1'b0);
        check("bp_resp_valid", resp_valid, 1'b1);
        @(posedge clka); #1;
        resp_ready = 1'b1;
        @(negedge clka);
        check("bp_ready_before_pop", req_ready, 1'b0);
        @(posedge clka); #1;
        @(negedge clka);
        check("bp_ready_after_pop", req_ready, 1'b1);
        if (req_valid && req_ready) acc++;
        k = 0;
        while (acc < 4 && k < 20) begin
            @(posedge clka); #1;
            req_addr = AW'(16 + acc);
            @(negedge clka);
            if (req_valid && req_ready) acc++;
            k++;
        end
        @(posedge clka); #1;
        req_valid = 1'b0;
        check("bp_all_accepted", acc, 4);
        drain();

`ifdef PRAM_CTRL_RMW_EN
        // Partial write as read-modify-write.
        send(1'b1, 10'd9, 32'h11223344, 4'hF);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 10'd9;
        req_wdata = 32'hAABBCCDD;
        req_wstrb = 4'b0101;
        @(negedge clka);
        check("rmw_a_ready", req_ready, 1'b1);
        check("rmw_a_ena", ram_ena, 1'b1);
        check("rmw_a_wea", ram_wea, 1'b0);
        @(posedge clka); #1;
        req_valid = 1'b0;
        @(negedge clka);
        check("rmw_a1_wea", ram_wea, 1'b1);
        check("rmw_a1_dina", ram_dina, 32'h11BB33DD);
        check("rmw_a1_req_ready", req_ready, 1'b0);
        check("rmw_a1_resp_valid", resp_valid, 1'b0);
        @(posedge clka); #1;
        @(negedge clka);
        check("rmw_a2_resp_valid", resp_valid, 1'b1);
        check("rmw_a2_resp_wen", resp_wen, 1'b1);
        check("rmw_a2_old", resp_rdata, 32'h11223344);
        check("rmw_a2_wea", ram_wea, 1'b0);
        @(posedge clka); #1;
        send(1'b0, 10'd9, 32'h0, 4'h0);
        send(1'b1, 10'd10, 32'h55667788, 4'h0);
        send(1'b0, 10'd10, 32'h0, 4'h0);
        drain();

        // Reset while the write half is pending: the write must never happen.
        saved     = ref_mem[9];
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 10'd9;
        req_wdata = 32'hCAFEF00D;
        req_wstrb = 4'b0011;
        @(negedge clka);
        @(posedge clka); #1;
        req_valid = 1'b0;
        rsta_n    = 1'b0;
        #1;
        check("rmw_rst_ena", ram_ena, 1'b0);
        @(posedge clka); #1;
        @(posedge clka); #1;
        rsta_n     = 1'b1;
        ref_mem[9] = saved;
        exp_q.delete();
        @(negedge clka);
        check("rmw_rst_resp_valid", resp_valid, 1'b0);
        check("rmw_rst_req_ready", req_ready, 1'b1);
        check("rmw_rst_mem", ram_mem[9], saved);
        @(posedge clka); #1;
        send(1'b0, 10'd9, 32'h0, 4'h0);
        drain();
`endif

        // Random traffic with random response backpressure.
        fired     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!req_valid || fired) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_wen   = 1'($urandom_range(0, 1));
                req_addr  = AW'($urandom_range(0, 15));
                req_wdata = $urandom;
                req_wstrb = SW'($urandom_range(0, 15));
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clka);
            fired = req_valid && req_ready;
            @(posedge clka); #1;
        end
        req_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
